pipe_rca: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. Operands of WIDTH bits are added in SEG-bit ripple segments, one segment per pipeline stage. A valid/ready handshake with full backpressure sits on both sides. It is the general-width, registered, streaming successor to the team's fixed 4-bit combinational ripple-carry adder, for datapaths that need wide adds at high clock rate.

---
 rtl/pipe_rca.sv | 132 +++++++++++++
 tb/tb_pipe_rca.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rca.sv
// pipe_rca: streaming ripple-carry adder/subtractor. Each pipeline stage resolves
// SEG sum bits and hands its carry plus the untouched operand slices to the next stage.
module pipe_rca #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SEG != 0) begin : g_bad_param
        $error("pipe_rca: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Returns {carry_out, carry_in_of_top_bit ^ carry_out, sum} for one segment.
    function automatic logic [SEG+1:0] ripple(input logic [SEG-1:0] x,
                                              input logic [SEG-1:0] y,
                                              input logic           ci);
        logic [SEG-1:0] sum;
        logic           c;
        logic           cm;
        c  = ci;
        cm = ci;
        for (int i = 0; i < SEG; i++) begin
            cm     = c;
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, cm ^ c, sum};
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] vsrc;
    logic              cy_p  [STAGES];
    logic              ov_p  [STAGES];
    logic [WIDTH-1:0]  sum_p [STAGES];
    logic [WIDTH-1:0]  a_p   [STAGES];
    logic [WIDTH-1:0]  b_p   [STAGES];

    logic [WIDTH-1:0]  sa    [STAGES];
    logic [WIDTH-1:0]  sb    [STAGES];
    logic [WIDTH-1:0]  ss    [STAGES];
    logic              sc    [STAGES];
    logic [WIDTH-1:0]  nsum  [STAGES];
    logic              ncy   [STAGES];
    logic              nov   [STAGES];

    // Stage inputs: stage 0 takes the ports, stage k takes register k-1.
    always_comb begin
        vsrc    = '0;
        vsrc[0] = in_valid;
        sa[0]   = a;
        sb[0]   = b ^ {WIDTH{sub}};
        ss[0]   = '0;
        sc[0]   = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            vsrc[k] = vld_p[k-1];
            sa[k]   = a_p[k-1];
            sb[k]   = b_p[k-1];
            ss[k]   = sum_p[k-1];
            sc[k]   = cy_p[k-1];
        end
    end

    always_comb begin
        logic [SEG+1:0] r;
        r = '0;
        for (int k = 0; k < STAGES; k++) begin
            r                     = ripple(sa[k][k*SEG +: SEG], sb[k][k*SEG +: SEG], sc[k]);
            nsum[k]               = ss[k];
            nsum[k][k*SEG +: SEG] = r[SEG-1:0];
            nov[k]                = r[SEG];
            ncy[k]                = r[SEG+1];
        end
    end

    // Load enables ripple backwards from the output handshake.
    always_comb begin
        logic e;
        en       = '0;
        e        = ~vld_p[LAST] | out_ready;
        en[LAST] = e;
        for (int k = LAST - 1; k >= 0; k--) begin
            e     = ~vld_p[k] | e;
            en[k] = e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) vld_p[k] <= vsrc[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (en[k] && vsrc[k]) begin
                sum_p[k] <= nsum[k];
                a_p[k]   <= sa[k];
                b_p[k]   <= sb[k];
                cy_p[k]  <= ncy[k];
                ov_p[k]  <= nov[k];
            end
        end
    end

    // Data registers are not reset, so outputs are masked by the last valid bit.
    assign in_ready  = en[0];
    assign out_valid = vld_p[LAST];
    assign s         = out_valid ? sum_p[LAST] : '0;
    assign cout      = out_valid & cy_p[LAST];
    assign ovf       = out_valid & ov_p[LAST];

endmodule

// File: tb/tb_pipe_rca.sv
// Scoreboard bench for pipe_rca: 16/4 main instance plus a single-stage 8/8 instance.
module tb_pipe_rca;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, s;
    logic        cin, sub, cout, ovf;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, s8;
    logic        cin8, sub8, cout8, ovf8;

    int          errors = 0;
    int          checks = 0;
    int          run    = 0;
    int          or_mode = 0;
    logic [17:0] q[$];

    pipe_rca #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    pipe_rca #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic sb);
        logic [15:0] be;
        logic [16:0] r;
        logic        o;
        be = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, be} + {16'b0, c ^ sb};
        o  = (x[15] == be[15]) && (r[15] != x[15]);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic sb, input logic [17:0] e);
        int w;
        a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w >= 200) break;
        end
        if (in_ready) begin
            q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready held 0 for %0d cycles, required 1", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 = stall, 1 = accept, otherwise 30% stall.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 99) >= 30);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer.
    initial begin : mon
        logic [17:0] e;
        logic [17:0] hv;
        logic        held;
        int          cnt;
        held = 1'b0;
        cnt  = 0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt  = 0;
                held = 1'b0;
                run  = 0;
            end else begin
                chk("in_ready", in_ready, (cnt == 4 && !out_ready) ? 32'd0 : 32'd1);
                if (held) begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_data", {ovf, cout, s}, hv);
                end
                held = out_valid && !out_ready;
                hv   = {ovf, cout, s};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got s=%h with empty scoreboard, required none", s);
                    end else begin
                        e = q.pop_front();
                        chk("result", {ovf, cout, s}, e);
                    end
                    run++;
                end else begin
                    run = 0;
                end
                if (in_valid && in_ready) cnt++;
                if (out_valid && out_ready) cnt--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] dx [7] = '{16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010, 16'hFFFF, 16'h8000};
        logic [15:0] dy [7] = '{16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0001, 16'hFFFF, 16'h8000};
        logic        dc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        ds [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [17:0] de [7] = '{{2'b10, 16'h8000}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                                {2'b00, 16'h5556}, {2'b01, 16'h000E}, {2'b01, 16'hFFFF},
                                {2'b11, 16'h0000}};
        logic [15:0] x, y;
        logic        c, sb;
        int          cyc, mx, seen;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        #2;
        chk("reset_outputs", {out_valid, cout, ovf, s}, 0);
        chk("reset_outputs8", {out_valid8, cout8, ovf8, s8}, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        // Single-stage instance: latency of one edge.
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", in_ready8, 1);
        chk("w8_not_yet_valid", out_valid8, 0);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_latency_valid", out_valid8, 1);
        chk("w8_result", {ovf8, cout8, s8}, {2'b01, 8'h01});
        @(negedge clk);
        chk("w8_consumed", out_valid8, 0);

        // Directed vectors, out_ready held high.
        or_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h0000});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        chk("latency_cycles", cyc, 4);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) issue(dx[i], dy[i], dc[i], ds[i], de[i]);
        drain("drain_directed");

        // Asynchronous reset with three transactions in flight.
        or_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        issue(16'hA5A5, 16'h0F0F, 1'b1, 1'b1, model(16'hA5A5, 16'h0F0F, 1'b1, 1'b1));
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, model(16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("stalled_before_reset", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {out_valid, cout, ovf, s}, 0);
        q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        or_mode = 1;
        @(posedge clk);
        #3;
        chk("in_ready_after_midreset", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale_result", seen, 0);
        @(posedge clk);
        #1;

        // Full throughput: 50 back-to-back transactions.
        for (int i = 0; i < 50; i++) begin
            x  = 16'(i * 16'h0101);
            y  = 16'(16'hFFFF - i * 16'h0303);
            c  = 1'(i);
            sb = 1'(i >> 1);
            issue(x, y, c, sb, model(x, y, c, sb));
        end
        mx = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (run > mx) mx = run;
        end
        chk("throughput_consecutive", mx, 50);
        drain("drain_throughput");

        // Random stream with random gaps and 30% backpressure.
        or_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                @(posedge clk);
                #1;
            end
            x  = 16'($urandom);
            y  = 16'($urandom);
            c  = 1'($urandom);
            sb = 1'($urandom);
            issue(x, y, c, sb, model(x, y, c, sb));
        end
        or_mode = 1;
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
